systolic_feed_ctrl: RTL and testbench

Sequencing controller for the systolic-array input path. Accepts a job of K input vectors over a valid/ready stream, drives the shared enable, tile select and data of the triangle skew arrays and PE array, then injects zero vectors to flush the skew and PE pipelines. Sits between the input vector buffer and the 8×8 input parser / PE array; one job at a time.

---
 rtl/systolic_feed_ctrl_if.sv | 35 +++
 rtl/systolic_feed_ctrl.sv | 115 +++++++++++
 tb/tb_systolic_feed_ctrl.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/systolic_feed_ctrl_if.sv
// Stream, job-control and skew/PE drive signals of the systolic input-path controller.
// master = job/stream source side, slave = controller side.
interface systolic_feed_ctrl_if #(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 16,
  parameter int KW         = 16
);
  logic                         start;
  logic                         tile_in;
  logic [KW-1:0]                k_len;
  logic                         abort;
  logic                         in_valid;
  logic                         in_ready;
  logic [2*N*DATA_WIDTH-1:0]    in_data;
  logic                         skew_en;
  logic                         skew_tile;
  logic [N*DATA_WIDTH-1:0]      skew_in_0;
  logic [N*DATA_WIDTH-1:0]      skew_in_1;
  logic                         pe_en;
  logic                         pe_clear;
  logic                         busy;
  logic                         done;

  modport master (
    output start, tile_in, k_len, abort, in_valid, in_data,
    input  in_ready, skew_en, skew_tile, skew_in_0, skew_in_1,
           pe_en, pe_clear, busy, done
  );

  modport slave (
    input  start, tile_in, k_len, abort, in_valid, in_data,
    output in_ready, skew_en, skew_tile, skew_in_0, skew_in_1,
           pe_en, pe_clear, busy, done
  );
endinterface

// File: rtl/systolic_feed_ctrl.sv
// Job sequencer for the systolic input path: clear accumulators, feed K vectors
// through the skew arrays, then flush the skew/PE pipelines with zero vectors.
module systolic_feed_ctrl #(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 16,
  parameter int KW         = 16,
  parameter int FLUSH_NORM = 2*N-1,
  parameter int FLUSH_TILE = N+1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  systolic_feed_ctrl_if.slave  bus
);
  localparam int W = N*DATA_WIDTH;
  localparam logic [KW-1:0] FLUSH_NORM_LAST = KW'(FLUSH_NORM-1);
  localparam logic [KW-1:0] FLUSH_TILE_LAST = KW'(FLUSH_TILE-1);

  typedef enum logic [2:0] {IDLE, CLEAR, FEED, FLUSH, DONE} state_t;

  state_t        state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [KW-1:0] feed_cnt_q, feed_cnt_d;
  logic [KW-1:0] flush_cnt_q, flush_cnt_d;
  logic          tile_q, tile_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      k_q         <= '0;
      feed_cnt_q  <= '0;
      flush_cnt_q <= '0;
      tile_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      feed_cnt_q  <= feed_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      tile_q      <= tile_d;
    end
  end

  always_comb begin
    logic          beat;
    logic [KW-1:0] flush_last;

    state_d     = state_q;
    k_d         = k_q;
    feed_cnt_d  = feed_cnt_q;
    flush_cnt_d = flush_cnt_q;
    tile_d      = tile_q;

    bus.in_ready  = 1'b0;
    bus.skew_en   = 1'b0;
    bus.skew_in_0 = '0;
    bus.skew_in_1 = '0;
    beat          = 1'b0;
    flush_last    = tile_q ? FLUSH_TILE_LAST : FLUSH_NORM_LAST;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          k_d     = bus.k_len;
          tile_d  = bus.tile_in;
          state_d = (bus.k_len == '0) ? DONE : CLEAR;
        end
      end
      CLEAR: begin
        feed_cnt_d = '0;
        state_d    = FEED;
      end
      FEED: begin
        bus.in_ready = 1'b1;
        beat         = bus.in_valid;
        if (beat) begin
          bus.skew_en   = 1'b1;
          bus.skew_in_0 = bus.in_data[W-1:0];
          bus.skew_in_1 = tile_q ? bus.in_data[2*W-1:W] : '0;
          feed_cnt_d    = feed_cnt_q + 1'b1;
          // k_q is nonzero here, so k_q-1 cannot underflow; max k_len never wraps feed_cnt
          if (feed_cnt_q == k_q - 1'b1) begin
            flush_cnt_d = '0;
            state_d     = FLUSH;
          end
        end
      end
      FLUSH: begin
        bus.skew_en = 1'b1;
        flush_cnt_d = flush_cnt_q + 1'b1;
        if (flush_cnt_q == flush_last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        feed_cnt_d  = '0;
        flush_cnt_d = '0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (bus.abort && (state_q != IDLE)) begin
      state_d     = IDLE;
      feed_cnt_d  = '0;
      flush_cnt_d = '0;
    end
  end

  always_comb begin
    bus.pe_en     = bus.skew_en;
    bus.pe_clear  = (state_q == CLEAR);
    bus.busy      = (state_q != IDLE);
    bus.done      = (state_q == DONE);
    bus.skew_tile = (state_q != IDLE) && tile_q;
  end
endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// Randomized bench: each job's expected per-cycle output trace is derived from the
// job rules (clear, K beats, F zero-vector flush cycles, done) and compared cycle by cycle.
module tb_systolic_feed_ctrl;
  localparam int N  = 8;
  localparam int DW = 16;
  localparam int KW = 16;
  localparam int W  = N*DW;

  typedef struct {
    bit             v;
    logic [2*W-1:0] d;
    bit             rdy, sen, clr, bsy, dn, stile;
    logic [W-1:0]   s0, s1;
  } cyc_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  systolic_feed_ctrl_if #(.N(N), .DATA_WIDTH(DW), .KW(KW)) bus ();

  systolic_feed_ctrl #(.N(N), .DATA_WIDTH(DW), .KW(KW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check_eq(input string tag, input logic [2*W-1:0] got, input logic [2*W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs(input string pfx, input cyc_t e);
    check_eq({pfx, " in_ready"},  2*W'(bus.in_ready),  2*W'(e.rdy));
    check_eq({pfx, " skew_en"},   2*W'(bus.skew_en),   2*W'(e.sen));
    check_eq({pfx, " pe_en"},     2*W'(bus.pe_en),     2*W'(e.sen));
    check_eq({pfx, " pe_clear"},  2*W'(bus.pe_clear),  2*W'(e.clr));
    check_eq({pfx, " busy"},      2*W'(bus.busy),      2*W'(e.bsy));
    check_eq({pfx, " done"},      2*W'(bus.done),      2*W'(e.dn));
    check_eq({pfx, " skew_tile"}, 2*W'(bus.skew_tile), 2*W'(e.stile));
    check_eq({pfx, " skew_in_0"}, 2*W'(bus.skew_in_0), 2*W'(e.s0));
    check_eq({pfx, " skew_in_1"}, 2*W'(bus.skew_in_1), 2*W'(e.s1));
  endtask

  function automatic logic [2*W-1:0] rand_vec();
    logic [2*W-1:0] d;
    for (int i = 0; i < 2*W/32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  function automatic cyc_t idle_cycle();
    cyc_t c;
    c.v = 1'($urandom % 2);
    c.d = rand_vec();
    c.rdy = 0; c.sen = 0; c.clr = 0; c.bsy = 0; c.dn = 0; c.stile = 0;
    c.s0 = '0; c.s1 = '0;
    return c;
  endfunction

  // mode 0: in_valid always high, 1: 1,0,1,0..., 2: random
  task automatic run_job(input int k, input bit tile, input int mode, input int abort_at);
    cyc_t q[$];
    cyc_t c;
    int   beats, j, f;
    bit   aborted;

    q.push_back(idle_cycle());
    c = idle_cycle();
    c.bsy = 1; c.stile = tile;
    if (k == 0) begin
      c.dn = 1;
      q.push_back(c);
    end else begin
      c.clr = 1;
      q.push_back(c);
      beats = 0;
      j = 0;
      while (beats < k) begin
        c = idle_cycle();
        c.bsy = 1; c.stile = tile; c.rdy = 1;
        c.v = (mode == 0) ? 1'b1 : (mode == 1) ? (j % 2 == 0) : ($urandom % 4 != 0);
        if (c.v) begin
          c.sen = 1;
          c.s0  = c.d[W-1:0];
          c.s1  = tile ? c.d[2*W-1:W] : '0;
          beats++;
        end
        q.push_back(c);
        j++;
      end
      f = tile ? N+1 : 2*N-1;
      for (int i = 0; i < f; i++) begin
        c = idle_cycle();
        c.bsy = 1; c.stile = tile; c.sen = 1;
        q.push_back(c);
      end
      c = idle_cycle();
      c.bsy = 1; c.stile = tile; c.dn = 1;
      q.push_back(c);
    end

    aborted = 0;
    for (int cyc = 0; cyc < q.size() && !aborted; cyc++) begin
      @(negedge clk);
      // extra start requests while busy must be ignored; abort in IDLE must be ignored
      bus.start    = (cyc == 0) ? 1'b1 : 1'($urandom % 2);
      bus.k_len    = (cyc == 0) ? KW'(k) : KW'($urandom_range(1, 20));
      bus.tile_in  = (cyc == 0) ? tile : 1'($urandom % 2);
      bus.abort    = (cyc == 0) ? 1'($urandom % 2) : (cyc == abort_at);
      bus.in_valid = q[cyc].v;
      bus.in_data  = q[cyc].d;
      #1;
      check_outputs($sformatf("k%0d t%0d c%0d", k, tile, cyc), q[cyc]);
      if (cyc == abort_at) aborted = 1;
    end

    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      c = idle_cycle();
      bus.start    = 1'b0;
      bus.abort    = 1'($urandom % 2);
      bus.in_valid = c.v;
      bus.in_data  = c.d;
      #1;
      check_outputs($sformatf("k%0d idle%0d", k, i), c);
    end
    bus.abort = 1'b0;
  endtask

  task automatic reset_mid_feed();
    cyc_t z;
    z = idle_cycle();
    @(negedge clk);
    bus.start = 1'b1; bus.k_len = KW'(6); bus.tile_in = 1'b1; bus.abort = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = rand_vec();
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check_eq("rst beat2 skew_en", 2*W'(bus.skew_en), 2*W'(1'b1));
    rst_n = 1'b0;
    #1;
    check_outputs("rst async", z);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_outputs("rst after", z);
  endtask

  initial begin
    cyc_t z;
    bus.start = 0; bus.tile_in = 0; bus.k_len = '0; bus.abort = 0;
    bus.in_valid = 0; bus.in_data = '0;
    repeat (2) @(negedge clk);
    z = idle_cycle();
    bus.in_valid = 1'b1;
    #1;
    check_outputs("reset", z);
    rst_n = 1'b1;

    run_job(4, 1'b0, 0, -1);
    run_job(3, 1'b1, 0, -1);
    run_job(5, 1'b0, 1, -1);
    run_job(0, 1'b0, 0, -1);
    run_job(4, 1'b0, 0, 8);
    run_job(3, 1'b0, 0, -1);
    reset_mid_feed();
    run_job(2, 1'b1, 2, -1);
    for (int i = 0; i < 25; i++) begin
      run_job($urandom_range(0, 12), 1'($urandom % 2), $urandom_range(0, 2),
              ($urandom % 4 == 0) ? $urandom_range(1, 10) : -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
